// File: rtl/branch_stage.sv
// branch_stage
//   Clocked packet branch stage. One 38-bit packet stream arrives over a
//   Send/Ack handshake. Each packet is routed by bit SEL_BIT to the EXTERNAL
//   port (bit = 1) or the INTERNAL port (bit = 0). Each port has its own
//   DEPTH-entry FIFO, so a stalled port only blocks traffic aimed at it.
//
// Parameters
//   SEL_BIT  packet bit that selects the route (default 37)
//   DEPTH    entries per output FIFO, power of two, >= 2 (default 2)
//
// Ports
//   CP             clock, rising edge
//   MR_N           asynchronous active-low master reset
//   Send_in        upstream packet valid
//   PACKET_IN      incoming packet
//   Ack_out        packet accepted this cycle (combinational)
//   Send_out_EX    EXTERNAL FIFO non-empty
//   PACKET_OUT_EX  EXTERNAL FIFO head (0 when empty)
//   Ack_in_EX      EXTERNAL consumer takes the head
//   Send_out_IN    INTERNAL FIFO non-empty
//   PACKET_OUT_IN  INTERNAL FIFO head (0 when empty)
//   Ack_in_IN      INTERNAL consumer takes the head
//   Cnt_EX/Cnt_IN  16-bit push counters, only with BRANCH_STAGE_PKT_CNT_EN
//
// Optional feature macro: BRANCH_STAGE_PKT_CNT_EN
module branch_stage #(
  parameter int SEL_BIT = 37,
  parameter int DEPTH   = 2
) (
  input  logic        CP,
  input  logic        MR_N,
  input  logic        Send_in,
  input  logic [37:0] PACKET_IN,
  output logic        Ack_out,
  output logic        Send_out_EX,
  output logic [37:0] PACKET_OUT_EX,
  input  logic        Ack_in_EX,
  output logic        Send_out_IN,
  output logic [37:0] PACKET_OUT_IN,
  input  logic        Ack_in_IN
`ifdef BRANCH_STAGE_PKT_CNT_EN
  ,
  output logic [15:0] Cnt_EX,
  output logic [15:0] Cnt_IN
`endif
);

  localparam int DATA_W = 38;
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  // Array index per port; matches the value of the routing bit.
  localparam int EX = 1;
  localparam int IN = 0;

  logic [DATA_W-1:0] mem_q [2][DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q [2];
  logic [PTR_W-1:0]  wr_ptr_d [2];
  logic [PTR_W-1:0]  rd_ptr_q [2];
  logic [PTR_W-1:0]  rd_ptr_d [2];
  logic [CNT_W-1:0]  cnt_q [2];
  logic [CNT_W-1:0]  cnt_d [2];
  logic              full [2];
  logic              nempty [2];
  logic              push [2];
  logic              pop [2];
  logic              ack_in [2];
  logic              sel;

  assign ack_in[EX] = Ack_in_EX;
  assign ack_in[IN] = Ack_in_IN;

  // Acceptance looks only at the current count: a full FIFO never accepts,
  // even when it is being popped in the same cycle.
  always_comb begin
    sel = PACKET_IN[SEL_BIT];
    for (int p = 0; p < 2; p++) begin
      full[p]   = (cnt_q[p] == FULL_CNT);
      nempty[p] = (cnt_q[p] != '0);
    end
    Ack_out = sel ? !full[EX] : !full[IN];
  end

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      push[p]     = Send_in && Ack_out && (sel == (p == EX));
      pop[p]      = nempty[p] && ack_in[p];
      wr_ptr_d[p] = wr_ptr_q[p];
      rd_ptr_d[p] = rd_ptr_q[p];
      cnt_d[p]    = cnt_q[p];
      if (push[p]) wr_ptr_d[p] = wr_ptr_q[p] + PTR_W'(1);
      if (pop[p])  rd_ptr_d[p] = rd_ptr_q[p] + PTR_W'(1);
      case ({push[p], pop[p]})
        2'b10:   cnt_d[p] = cnt_q[p] + CNT_W'(1);
        2'b01:   cnt_d[p] = cnt_q[p] - CNT_W'(1);
        default: cnt_d[p] = cnt_q[p];
      endcase
    end
  end

  always_ff @(posedge CP or negedge MR_N) begin
    if (!MR_N) begin
      for (int p = 0; p < 2; p++) begin
        wr_ptr_q[p] <= '0;
        rd_ptr_q[p] <= '0;
        cnt_q[p]    <= '0;
      end
    end else begin
      for (int p = 0; p < 2; p++) begin
        wr_ptr_q[p] <= wr_ptr_d[p];
        rd_ptr_q[p] <= rd_ptr_d[p];
        cnt_q[p]    <= cnt_d[p];
      end
    end
  end

  // Storage carries no reset; the head is masked to 0 whenever the FIFO is
  // empty, which covers the reset-state output value.
  always_ff @(posedge CP) begin
    for (int p = 0; p < 2; p++) begin
      if (push[p]) mem_q[p][wr_ptr_q[p]] <= PACKET_IN;
    end
  end

  assign Send_out_EX   = nempty[EX];
  assign Send_out_IN   = nempty[IN];
  assign PACKET_OUT_EX = nempty[EX] ? mem_q[EX][rd_ptr_q[EX]] : '0;
  assign PACKET_OUT_IN = nempty[IN] ? mem_q[IN][rd_ptr_q[IN]] : '0;

`ifdef BRANCH_STAGE_PKT_CNT_EN
  logic [15:0] cnt_ex_q;
  logic [15:0] cnt_in_q;

  always_ff @(posedge CP or negedge MR_N) begin
    if (!MR_N) begin
      cnt_ex_q <= '0;
      cnt_in_q <= '0;
    end else begin
      if (push[EX]) cnt_ex_q <= cnt_ex_q + 16'd1;
      if (push[IN]) cnt_in_q <= cnt_in_q + 16'd1;
    end
  end

  assign Cnt_EX = cnt_ex_q;
  assign Cnt_IN = cnt_in_q;
`endif

endmodule

// File: tb/tb_branch_stage.sv
module tb_branch_stage;

  logic        CP;
  logic        MR_N;
  logic        Send_in;
  logic [37:0] PACKET_IN;
  logic        Ack_out;
  logic        Send_out_EX;
  logic [37:0] PACKET_OUT_EX;
  logic        Ack_in_EX;
  logic        Send_out_IN;
  logic [37:0] PACKET_OUT_IN;
  logic        Ack_in_IN;
`ifdef BRANCH_STAGE_PKT_CNT_EN
  logic [15:0] Cnt_EX;
  logic [15:0] Cnt_IN;
`endif

  branch_stage #(.SEL_BIT(37), .DEPTH(2)) dut (
    .CP            (CP),
    .MR_N          (MR_N),
    .Send_in       (Send_in),
    .PACKET_IN     (PACKET_IN),
    .Ack_out       (Ack_out),
    .Send_out_EX   (Send_out_EX),
    .PACKET_OUT_EX (PACKET_OUT_EX),
    .Ack_in_EX     (Ack_in_EX),
    .Send_out_IN   (Send_out_IN),
    .PACKET_OUT_IN (PACKET_OUT_IN),
    .Ack_in_IN     (Ack_in_IN)
`ifdef BRANCH_STAGE_PKT_CNT_EN
    ,
    .Cnt_EX        (Cnt_EX),
    .Cnt_IN        (Cnt_IN)
`endif
  );

  initial CP = 1'b0;
  always #5 CP = ~CP;

  int total  = 0;
  int passed = 0;
  int rx_in  = 0;
  int exp_cnt_ex = 0;
  int exp_cnt_in = 0;
  logic [37:0] exp_ex [$];
  logic [37:0] exp_in [$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Expected-value bookkeeping for an accepted packet.
  task automatic record(input logic [37:0] pkt);
    if (pkt[37]) begin
      exp_ex.push_back(pkt);
      exp_cnt_ex++;
    end else begin
      exp_in.push_back(pkt);
      exp_cnt_in++;
    end
  endtask

  // One-cycle offer: inputs change 1 time unit after the rising edge,
  // acceptance is judged mid-cycle.
  task automatic send(input logic [37:0] pkt, output bit acc);
    Send_in   = 1'b1;
    PACKET_IN = pkt;
    @(negedge CP);
    acc = Ack_out;
    if (acc) record(pkt);
    @(posedge CP);
    #1;
    Send_in = 1'b0;
  endtask

  // Scoreboard monitor: every transfer on an output port is compared with
  // the oldest expected packet for that port.
  always @(negedge CP) begin
    if (MR_N) begin
      if (Send_out_EX && Ack_in_EX) begin
        if (exp_ex.size() == 0) begin
          total++;
          $display("FAIL ex_unexpected: got %0h expected no packet", PACKET_OUT_EX);
        end else chk("ex_data", PACKET_OUT_EX, exp_ex.pop_front());
      end
      if (Send_out_IN && Ack_in_IN) begin
        rx_in++;
        if (exp_in.size() == 0) begin
          total++;
          $display("FAIL in_unexpected: got %0h expected no packet", PACKET_OUT_IN);
        end else chk("in_data", PACKET_OUT_IN, exp_in.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;
    bit got;
    int base;

    MR_N      = 1'b0;
    Send_in   = 1'b0;
    PACKET_IN = '0;
    Ack_in_EX = 1'b0;
    Ack_in_IN = 1'b0;

    // Reset state
    #12;
    chk("rst_send_ex", Send_out_EX, 0);
    chk("rst_send_in", Send_out_IN, 0);
    chk("rst_pkt_ex", PACKET_OUT_EX, 0);
    chk("rst_pkt_in", PACKET_OUT_IN, 0);
    chk("rst_ack_out", Ack_out, 1);
    @(posedge CP);
    #1;
    MR_N = 1'b1;

    // Routing and one-cycle latency
    Ack_in_EX = 1'b1;
    Ack_in_IN = 1'b1;
    send(38'h20_0000_0001, acc);
    chk("route_acc_ex", acc, 1);
    chk("route_ex_valid", Send_out_EX, 1);
    chk("route_ex_head", PACKET_OUT_EX, 38'h20_0000_0001);
    chk("route_in_idle", Send_out_IN, 0);
    send(38'h00_0000_0002, acc);
    chk("route_acc_in", acc, 1);
    chk("route_in_valid", Send_out_IN, 1);
    chk("route_in_head", PACKET_OUT_IN, 38'h00_0000_0002);
    chk("route_ex_drained", Send_out_EX, 0);

    // Backpressure on EX while IN keeps flowing
    Ack_in_EX = 1'b0;
    send(38'h20_0000_00A1, acc);
    chk("full_acc_a", acc, 1);
    send(38'h20_0000_00B2, acc);
    chk("full_acc_b", acc, 1);
    chk("full_ex_head", PACKET_OUT_EX, 38'h20_0000_00A1);
    Send_in   = 1'b1;
    PACKET_IN = 38'h20_0000_00C3;
    @(negedge CP);
    chk("full_ack_c", Ack_out, 0);
    @(posedge CP);
    #1;
    send(38'h00_0000_00D4, acc);
    chk("full_acc_in_d", acc, 1);
    chk("full_ex_hold", PACKET_OUT_EX, 38'h20_0000_00A1);

    // Full with a pop in the same cycle: still refused, accepted next cycle
    Send_in   = 1'b1;
    PACKET_IN = 38'h20_0000_00C3;
    Ack_in_EX = 1'b1;
    @(negedge CP);
    chk("full_pop_ack", Ack_out, 0);
    @(posedge CP);
    #1;
    chk("after_pop_ack", Ack_out, 1);
    chk("after_pop_head", PACKET_OUT_EX, 38'h20_0000_00B2);
    send(38'h20_0000_00C3, acc);
    chk("full_acc_c", acc, 1);
    repeat (4) @(posedge CP);
    #1;
    chk("full_drain_ex", exp_ex.size(), 0);
    chk("full_drain_in", exp_in.size(), 0);

    // Wrap-around with random INTERNAL stalls
    base = rx_in;
    for (int i = 0; i < 10; i++) begin
      Send_in   = 1'b1;
      PACKET_IN = 38'(i);
      got       = 1'b0;
      for (int t = 0; t < 40 && !got; t++) begin
        Ack_in_IN = 1'($urandom_range(0, 1));
        @(negedge CP);
        if (Ack_out) begin
          got = 1'b1;
          record(38'(i));
        end
        @(posedge CP);
        #1;
      end
      chk("wrap_accept", got, 1);
    end
    Send_in   = 1'b0;
    Ack_in_IN = 1'b1;
    for (int t = 0; t < 20 && exp_in.size() != 0; t++) @(posedge CP);
    #1;
    chk("wrap_drain", exp_in.size(), 0);
    chk("wrap_rx_count", rx_in - base, 10);
    chk("wrap_idle", Send_out_IN, 0);

`ifdef BRANCH_STAGE_PKT_CNT_EN
    chk("cnt_ex", Cnt_EX, 16'(exp_cnt_ex));
    chk("cnt_in", Cnt_IN, 16'(exp_cnt_in));
`endif

    // Reset mid-stream with both FIFOs occupied
    Ack_in_EX = 1'b0;
    Ack_in_IN = 1'b0;
    send(38'h20_0000_0E01, acc);
    send(38'h20_0000_0E02, acc);
    send(38'h00_0000_0101, acc);
    chk("mid_ex_valid", Send_out_EX, 1);
    chk("mid_in_valid", Send_out_IN, 1);
    #2;
    MR_N = 1'b0;
    #1;
    chk("mid_rst_send_ex", Send_out_EX, 0);
    chk("mid_rst_send_in", Send_out_IN, 0);
    chk("mid_rst_pkt_ex", PACKET_OUT_EX, 0);
    chk("mid_rst_pkt_in", PACKET_OUT_IN, 0);
    chk("mid_rst_ack", Ack_out, 1);
    exp_ex.delete();
    exp_in.delete();
    exp_cnt_ex = 0;
    exp_cnt_in = 0;
    @(posedge CP);
    #1;
    MR_N      = 1'b1;
    Ack_in_EX = 1'b1;
    Ack_in_IN = 1'b1;
    send(38'h20_0000_0E55, acc);
    chk("post_rst_acc", acc, 1);
    chk("post_rst_ex_valid", Send_out_EX, 1);
    chk("post_rst_ex_head", PACKET_OUT_EX, 38'h20_0000_0E55);
    chk("post_rst_in_idle", Send_out_IN, 0);
    repeat (3) @(posedge CP);
    #1;
    chk("final_drain_ex", exp_ex.size(), 0);
    chk("final_idle_ex", Send_out_EX, 0);

`ifdef BRANCH_STAGE_PKT_CNT_EN
    chk("cnt_ex_post_rst", Cnt_EX, 16'(exp_cnt_ex));
    chk("cnt_in_post_rst", Cnt_IN, 16'(exp_cnt_in));
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
